// File: rtl/range_coalescer_16.sv
// Coalesces a sorted block of 16 {start, end} ranges into merged, disjoint ranges.
// Overlapping and adjacent ranges are merged; pairs with start > end are padding.
`ifndef ARR_16_FLAT_WIDTH
`define ARR_16_FLAT_WIDTH (32*W)
`endif

module range_coalescer_16 #(
    parameter int W = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           valid_in,
    output logic                           ready_out,
    input  logic [`ARR_16_FLAT_WIDTH-1:0]  pairs_in_flat,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic [2*W-1:0]                 pair_out,
    output logic                           last_out
);

    // state | meaning
    // IDLE  | waiting for a block; ready_out high
    // SCAN  | walking pair[idx], merging into acc
    // FLUSH | emitting the final acc with last_out
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

    typedef struct packed {
        logic [W-1:0] start_val;
        logic [W-1:0] end_val;
    } tuple_pair_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    tuple_pair_t acc_q, acc_d;
    logic        acc_valid_q, acc_valid_d;
    tuple_pair_t buf_q [16];
    tuple_pair_t buf_d [16];
    logic        out_valid_q, out_valid_d;
    tuple_pair_t out_pair_q, out_pair_d;
    logic        out_last_q, out_last_d;

    logic        advance;
    tuple_pair_t cur;
    logic        cur_pad;
    logic [W:0]  acc_end_p1;
    logic        cur_merges;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_valid_q <= acc_valid_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Datapath registers whose contents are qualified by the flags above.
    always_ff @(posedge clock) begin
        acc_q      <= acc_d;
        out_pair_q <= out_pair_d;
        buf_q      <= buf_d;
    end

    always_comb begin
        advance    = !out_valid_q || ready_in;
        cur        = buf_q[idx_q];
        cur_pad    = cur.start_val > cur.end_val;
        // One extra bit so an accumulator ending at the maximum value never wraps.
        acc_end_p1 = {1'b0, acc_q.end_val} + {{W{1'b0}}, 1'b1};
        cur_merges = {1'b0, cur.start_val} <= acc_end_p1;

        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;

        if (out_valid_q && ready_in) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    for (int i = 0; i < 16; i++) begin
                        buf_d[i] = pairs_in_flat[i*2*W +: 2*W];
                    end
                    idx_d       = '0;
                    acc_valid_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (advance) begin
                    if (!cur_pad) begin
                        if (!acc_valid_q) begin
                            acc_d       = cur;
                            acc_valid_d = 1'b1;
                        end else if (cur_merges) begin
                            if (cur.end_val > acc_q.end_val) begin
                                acc_d.end_val = cur.end_val;
                            end
                        end else begin
                            out_valid_d = 1'b1;
                            out_pair_d  = acc_q;
                            out_last_d  = 1'b0;
                            acc_d       = cur;
                        end
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (advance) begin
                    if (acc_valid_q) begin
                        out_valid_d = 1'b1;
                        out_pair_d  = acc_q;
                        out_last_d  = 1'b1;
                    end
                    acc_valid_d = 1'b0;
                    idx_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready_out = (state_q == IDLE);
        valid_out = out_valid_q;
        pair_out  = out_pair_q;
        last_out  = out_last_q;
    end

endmodule

// File: tb/tb_range_coalescer_16.sv
// Self-checking bench for range_coalescer_16: table of blocks with expected
// coalesced ranges, scoreboard queue checked on every valid output cycle.
module tb_range_coalescer_16;

    localparam int W = 16;
    localparam logic [W-1:0] MAXV = '1;

    logic              clock;
    logic              reset;
    logic              valid_in;
    logic              ready_out;
    logic [32*W-1:0]   pairs_in_flat;
    logic              valid_out;
    logic              ready_in;
    logic [2*W-1:0]    pair_out;
    logic              last_out;

    range_coalescer_16 #(.W(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .pairs_in_flat (pairs_in_flat),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .pair_out      (pair_out),
        .last_out      (last_out)
    );

    typedef struct packed {
        logic [15:0][W-1:0] s;
        logic [15:0][W-1:0] e;
        logic [15:0][W-1:0] xs;
        logic [15:0][W-1:0] xe;
        logic [4:0]         n_exp;
        logic               bp;
    } vec_t;

    typedef struct packed {
        logic [2*W-1:0] pair;
        logic           last;
    } exp_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    exp_t q [$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic bp_mode = 1'b0;
    int   bp_cnt = 0;
    logic [3:0] bp_pat = 4'b1001;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (bp_mode) begin
                ready_in = bp_pat[bp_cnt];
                bp_cnt = (bp_cnt + 1) % 4;
            end else begin
                ready_in = 1'b1;
            end
        end
    end

    // Scoreboard: every valid output cycle must show the head of the queue.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && valid_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got pair=%h last=%b want no output", pair_out, last_out);
                end else begin
                    if ({pair_out, last_out} !== {q[0].pair, q[0].last}) begin
                        errors++;
                        $display("FAIL out_pair got pair=%h last=%b want pair=%h last=%b",
                                 pair_out, last_out, q[0].pair, q[0].last);
                    end
                    if (ready_in) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int c;
        for (c = 0; c < 300; c++) begin
            @(negedge clock);
            if (ready_out) break;
        end
        if (c == 300) begin
            checks++;
            errors++;
            $display("FAIL wait_ready got 0 want 1");
        end
    endtask

    task automatic load_block(input int v);
        for (int i = 0; i < 16; i++) begin
            pairs_in_flat[i*2*W +: 2*W] = {vecs[v].s[i], vecs[v].e[i]};
        end
    endtask

    task automatic run_vec(input int v);
        int lat;
        int c;
        bp_mode = vecs[v].bp;
        wait_ready();
        load_block(v);
        for (int k = 0; k < 16; k++) begin
            if (k < int'(vecs[v].n_exp)) begin
                q.push_back({vecs[v].xs[k], vecs[v].xe[k], (k == int'(vecs[v].n_exp) - 1)});
            end
        end
        @(posedge clock);
        #1 valid_in = 1'b1;
        @(posedge clock);
        #1 valid_in = 1'b0;
        lat = 0;
        for (c = 1; c <= 300; c++) begin
            @(negedge clock);
            if (ready_out) begin
                lat = c;
                break;
            end
        end
        if (!vecs[v].bp) begin
            checks++;
            if (lat != 18) begin
                errors++;
                $display("FAIL latency_v%0d got %0d want 18", v, lat);
            end
        end
        for (c = 0; c < 300; c++) begin
            if (q.size() == 0 && !valid_out) break;
            @(negedge clock);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_v%0d got %0d pending want 0", v, q.size());
            q.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        pairs_in_flat = '0;

        for (int v = 0; v < NV; v++) vecs[v] = '0;
        for (int i = 0; i < 16; i++) begin
            vecs[0].s[i]  = W'(10*i);
            vecs[0].e[i]  = W'(10*i + 1);
            vecs[0].xs[i] = W'(10*i);
            vecs[0].xe[i] = W'(10*i + 1);
            vecs[1].s[i]  = W'(5);
            vecs[1].e[i]  = W'(0);
            vecs[2].s[i]  = W'(5);
            vecs[2].e[i]  = W'(0);
            vecs[4].s[i]  = W'(1);
            vecs[4].e[i]  = W'(0);
            vecs[5].s[i]  = W'(30);
            vecs[5].e[i]  = W'(0);
        end
        vecs[0].n_exp = 5'd16;
        vecs[3] = vecs[0];
        vecs[3].bp = 1'b1;

        vecs[1].s[0] = 1;  vecs[1].e[0] = 5;
        vecs[1].s[1] = 3;  vecs[1].e[1] = 8;
        vecs[1].s[2] = 9;  vecs[1].e[2] = 12;
        vecs[1].s[3] = 20; vecs[1].e[3] = 25;
        vecs[1].xs[0] = 1;  vecs[1].xe[0] = 12;
        vecs[1].xs[1] = 20; vecs[1].xe[1] = 25;
        vecs[1].n_exp = 5'd2;

        vecs[2].s[0] = 0;    vecs[2].e[0] = MAXV;
        vecs[2].s[1] = 7;    vecs[2].e[1] = 9;
        vecs[2].s[2] = MAXV; vecs[2].e[2] = MAXV;
        vecs[2].xs[0] = 0;   vecs[2].xe[0] = MAXV;
        vecs[2].n_exp = 5'd1;

        vecs[4].n_exp = 5'd0;

        vecs[5].s[0] = 2;  vecs[5].e[0] = 4;
        vecs[5].s[1] = 5;  vecs[5].e[1] = 0;
        vecs[5].s[2] = 5;  vecs[5].e[2] = 6;
        vecs[5].s[3] = 8;  vecs[5].e[3] = 8;
        vecs[5].s[4] = 10; vecs[5].e[4] = 3;
        vecs[5].s[5] = 10; vecs[5].e[5] = 20;
        vecs[5].s[6] = 15; vecs[5].e[6] = 18;
        vecs[5].s[7] = 21; vecs[5].e[7] = 21;
        vecs[5].xs[0] = 2;  vecs[5].xe[0] = 6;
        vecs[5].xs[1] = 8;  vecs[5].xe[1] = 8;
        vecs[5].xs[2] = 10; vecs[5].xe[2] = 21;
        vecs[5].n_exp = 5'd3;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks += 3;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_out); end
        if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_out); end
        if (last_out !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", last_out); end
        mon_en = 1'b1;

        for (int v = 0; v < NV; v++) run_vec(v);

        // Reset during SCAN at idx=7 with valid_in held high while busy.
        bp_mode = 1'b0;
        wait_ready();
        mon_en = 1'b0;
        load_block(0);
        @(posedge clock);
        #1 valid_in = 1'b1;
        @(posedge clock);
        #1 load_block(1);
        repeat (7) @(posedge clock);
        #1 valid_in = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({valid_out, pair_out} !== {1'b1, W'(50), W'(51)}) begin
            errors++;
            $display("FAIL pre_reset_out got v=%b pair=%h want v=1 pair=%h", valid_out, pair_out, {W'(50), W'(51)});
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks += 3;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", valid_out); end
        if (last_out !== 1'b0) begin errors++; $display("FAIL mid_rst_last got %b want 0", last_out); end
        if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", ready_out); end
        mon_en = 1'b1;
        repeat (25) @(negedge clock);
        run_vec(1);
        run_vec(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
